// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Receives a program image over an 8N1 UART line and writes it into the
// integrated computer's instruction memory. After the trailing checksum
// matches, the computer is released from reset and enabled.
//
// Frame: HEADER, count N (0 means 128 words), 4*N instruction bytes with
// each word sent MSB first, then one checksum byte equal to the XOR of all
// instruction bytes.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   rx             UART receive line (idles high, asynchronous to clk)
//   comp_rst       computer reset, active-low (0 = held in reset)
//   comp_en        computer enable, active-low (0 = running)
//   wr_instr_en    one-cycle instruction-memory write strobe
//   wr_instr_addr  instruction-memory word address
//   wr_instr       instruction word to write
//   busy           load in progress (COUNT, LOAD, CHECK)
//   done           computer released (RUN)
//   error          last load failed (ERROR)
//   words_loaded   words written in the current or last load (0..128)

module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        comp_rst,
  output logic        comp_en,
  output logic        wr_instr_en,
  output logic [6:0]  wr_instr_addr,
  output logic [31:0] wr_instr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  words_loaded
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  // Running XOR checksum over instruction bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic             rx_meta_r;
  logic             rx_sync_r;
  rx_state_t        rx_state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       rx_byte_r;
  logic             byte_valid_r;
  logic             frame_err_r;

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       word_total_r;
  logic [1:0]       byte_cnt_r;
  logic [23:0]      asm_r;
  logic [7:0]       csum_r;
  logic [7:0]       words_next_s;
  logic             last_word_s;

  // Two-flop synchronizer for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // UART byte receiver: half-bit start validation, then mid-bit sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r   <= RX_IDLE;
      bit_cnt_r    <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      rx_byte_r    <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          bit_cnt_r <= CNT_ZERO;
          if (!rx_sync_r) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (bit_cnt_r == HALF_LAST) begin
            bit_cnt_r <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            // Line back high at mid-start means it was a glitch.
            if (rx_sync_r) begin
              rx_state_r <= RX_IDLE;
            end else begin
              rx_state_r <= RX_DATA;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r <= CNT_ZERO;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r  <= CNT_ZERO;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              rx_byte_r    <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          bit_cnt_r  <= CNT_ZERO;
        end
      endcase
    end
  end

  // Word-completion helpers for the loader FSM.
  always_comb begin
    words_next_s = words_loaded + 8'd1;
    if (words_next_s == word_total_r) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
  end

  // Loader next-state logic, driven by received bytes and framing errors.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_RUN, S_ERROR: begin
        if (byte_valid_r && (rx_byte_r == HEADER)) begin
          state_next_s = S_COUNT;
        end else begin
          state_next_s = state_r;
        end
      end
      S_COUNT: begin
        if (frame_err_r) begin
          state_next_s = S_ERROR;
        end else if (byte_valid_r) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = state_r;
        end
      end
      S_LOAD: begin
        if (frame_err_r) begin
          state_next_s = S_ERROR;
        end else if (byte_valid_r && (byte_cnt_r == 2'd3) && last_word_s) begin
          state_next_s = S_CHECK;
        end else begin
          state_next_s = state_r;
        end
      end
      S_CHECK: begin
        if (frame_err_r) begin
          state_next_s = S_ERROR;
        end else if (byte_valid_r) begin
          if (rx_byte_r == csum_r) begin
            state_next_s = S_RUN;
          end else begin
            state_next_s = S_ERROR;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Loader state, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      word_total_r  <= 8'd0;
      byte_cnt_r    <= 2'd0;
      asm_r         <= 24'h000000;
      csum_r        <= 8'h00;
      comp_rst      <= 1'b0;
      comp_en       <= 1'b1;
      wr_instr_en   <= 1'b0;
      wr_instr_addr <= 7'd0;
      wr_instr      <= 32'h00000000;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      wr_instr_en <= 1'b0;

      // Outputs follow the state being entered so they change with it.
      comp_rst <= (state_next_s == S_RUN);
      comp_en  <= (state_next_s != S_RUN);
      busy     <= (state_next_s == S_COUNT) || (state_next_s == S_LOAD) ||
                  (state_next_s == S_CHECK);
      done     <= (state_next_s == S_RUN);
      error    <= (state_next_s == S_ERROR);

      // A HEADER starts a fresh load.
      if ((state_next_s == S_COUNT) && (state_r != S_COUNT)) begin
        words_loaded <= 8'd0;
        csum_r       <= 8'h00;
        byte_cnt_r   <= 2'd0;
      end

      if (byte_valid_r && (state_r == S_COUNT)) begin
        word_total_r <= (rx_byte_r == 8'h00) ? 8'd128 : rx_byte_r;
      end

      if (byte_valid_r && (state_r == S_LOAD)) begin
        asm_r      <= {asm_r[15:0], rx_byte_r};
        csum_r     <= csum_update(csum_r, rx_byte_r);
        byte_cnt_r <= byte_cnt_r + 2'd1;
        // Fourth byte of a word: memory is written now, before the
        // checksum is known; the computer stays in reset until it is.
        if (byte_cnt_r == 2'd3) begin
          wr_instr_en   <= 1'b1;
          wr_instr_addr <= words_loaded[6:0];
          wr_instr      <= {asm_r, rx_byte_r};
          words_loaded  <= words_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed testbench for uart_program_loader at CLKS_PER_BIT = 16.
module tb_uart_program_loader;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        comp_rst;
  logic        comp_en;
  logic        wr_instr_en;
  logic [6:0]  wr_instr_addr;
  logic [31:0] wr_instr;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe log collected by the monitor.
  int          strobe_cnt = 0;
  logic [6:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic        prev_en = 1'b0;
  logic        b2b_seen = 1'b0;
  logic        wl_bad = 1'b0;

  uart_program_loader #(
    .CLKS_PER_BIT(16),
    .HEADER      (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .comp_rst     (comp_rst),
    .comp_en      (comp_en),
    .wr_instr_en  (wr_instr_en),
    .wr_instr_addr(wr_instr_addr),
    .wr_instr     (wr_instr),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    prev_en <= wr_instr_en;
    if (wr_instr_en) begin
      if (strobe_cnt < 256) begin
        log_addr[strobe_cnt] <= wr_instr_addr;
        log_data[strobe_cnt] <= wr_instr;
      end
      strobe_cnt <= strobe_cnt + 1;
      if (prev_en) b2b_seen <= 1'b1;
      if (words_loaded != ({1'b0, wr_instr_addr} + 8'd1)) wl_bad <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame at 16 clocks per bit; stop bit shortened to 12 clocks,
  // followed by 2 idle clocks.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_val;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Two-word body of the reference frame after the header, then checksum.
  task automatic send_body(input logic [7:0] csum);
    logic [7:0] fr [0:8];
    fr = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h07, 8'hAC, 8'h08, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
    send_byte(csum, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_comp_rst"}, comp_rst, 32'd0);
    check({tag, "_comp_en"}, comp_en, 32'd1);
    check({tag, "_wr_en"}, wr_instr_en, 32'd0);
    check({tag, "_wr_addr"}, wr_instr_addr, 32'd0);
    check({tag, "_wr_instr"}, wr_instr, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_done"}, done, 32'd0);
    check({tag, "_error"}, error, 32'd0);
    check({tag, "_words"}, words_loaded, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Short glitch: no byte, nothing happens.
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", busy, 32'd0);
    check("glitch_error", error, 32'd0);
    check("glitch_strobes", strobe_cnt, 32'd0);

    // Non-header bytes in IDLE are ignored.
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("idle_ign_busy", busy, 32'd0);
    check("idle_ign_done", done, 32'd0);
    check("idle_ign_error", error, 32'd0);

    // Bad checksum 8A (correct is 8B).
    send_byte(8'hA5, 1'b1);
    check("bad_hdr_busy", busy, 32'd1);
    send_body(8'h8A);
    check("bad_error", error, 32'd1);
    check("bad_comp_rst", comp_rst, 32'd0);
    check("bad_comp_en", comp_en, 32'd1);
    check("bad_done", done, 32'd0);
    check("bad_busy", busy, 32'd0);
    check("bad_strobes", strobe_cnt, 32'd2);
    check("bad_words", words_loaded, 32'd2);

    // Good frame from ERROR.
    send_byte(8'hA5, 1'b1);
    check("good_hdr_busy", busy, 32'd1);
    check("good_hdr_words", words_loaded, 32'd0);
    check("good_hdr_error", error, 32'd0);
    send_body(8'h8B);
    check("good_done", done, 32'd1);
    check("good_comp_rst", comp_rst, 32'd1);
    check("good_comp_en", comp_en, 32'd0);
    check("good_error", error, 32'd0);
    check("good_words", words_loaded, 32'd2);
    check("good_strobes", strobe_cnt, 32'd4);
    check("good_addr0", log_addr[2], 32'd0);
    check("good_word0", log_data[2], 32'h20080007);
    check("good_addr1", log_addr[3], 32'd1);
    check("good_word1", log_data[3], 32'hAC080000);

    // Non-header byte in RUN is ignored.
    send_byte(8'h3C, 1'b1);
    check("run_ign_done", done, 32'd1);
    check("run_ign_comp_rst", comp_rst, 32'd1);

    // Reload from RUN re-asserts computer reset, then a framing error.
    send_byte(8'hA5, 1'b1);
    check("reload_comp_rst", comp_rst, 32'd0);
    check("reload_comp_en", comp_en, 32'd1);
    check("reload_busy", busy, 32'd1);
    check("reload_done", done, 32'd0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (32) @(negedge clk);
    check("frm_error", error, 32'd1);
    check("frm_busy", busy, 32'd0);
    check("frm_comp_rst", comp_rst, 32'd0);
    check("frm_strobes", strobe_cnt, 32'd4);
    send_byte(8'hA5, 1'b1);
    check("frm_hdr_busy", busy, 32'd1);
    check("frm_hdr_words", words_loaded, 32'd0);
    check("frm_hdr_error", error, 32'd0);

    // Reset during the second word.
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1);
    check("rmid_strobes1", strobe_cnt, 32'd5);
    check("rmid_addr0", log_addr[4], 32'd0);
    check("rmid_word0", log_data[4], 32'h20080007);
    check("rmid_words1", words_loaded, 32'd1);
    send_byte(8'hAC, 1'b1);
    send_byte(8'h08, 1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rmid");
    repeat (200) @(negedge clk);
    check("rmid_strobes2", strobe_cnt, 32'd5);
    check("rmid_busy2", busy, 32'd0);

    // Count 0: 128 words of 11111111, checksum 00.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 512; i++) send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    check("c0_strobes", strobe_cnt, 32'd133);
    check("c0_first_addr", log_addr[5], 32'd0);
    check("c0_last_addr", log_addr[132], 32'd127);
    check("c0_last_word", log_data[132], 32'h11111111);
    check("c0_words", words_loaded, 32'd128);
    check("c0_done", done, 32'd1);
    check("c0_comp_rst", comp_rst, 32'd1);
    check("c0_error", error, 32'd0);

    check("no_back_to_back", b2b_seen, 32'd0);
    check("words_with_strobe", wl_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Receives a program image over a UART serial line and streams it into the integrated computer's instruction-memory write port. It replaces the fixed-ROM programming state machine on the hardware test top, so programs load without resynthesis. It drives the computer's reset, enable and instruction-write ports directly. After a verified load it releases the computer to run.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200 baud); must be ≥ 8.
- HEADER, default 8'hA5: sync byte that starts a load.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART receive line; idles high; 8N1, LSB first. Asynchronous to clk.
- comp_rst  out  1  computer reset, active-low (0 = computer held in reset).
- comp_en  out  1  computer enable, active-low (0 = computer runs).
- wr_instr_en  out  1  one-cycle instruction-memory write strobe.
- wr_instr_addr  out  7  write address (word index).
- wr_instr  out  32  instruction word to write.
- busy  out  1  high while a load is in progress.
- done  out  1  high while the computer is released (RUN).
- error  out  1  high in ERROR state.
- words_loaded  out  8  words written in the current or last load (0–128).

## Operation
- Load frame: HEADER, count byte N, 4·N instruction bytes (MSB first per word), checksum byte. N = 0 means 128 words. Checksum = XOR of all 4·N instruction bytes.
- Receiver:
  - rx passes through a 2-FF synchronizer.
  - A falling edge starts a bit timer. At CLKS_PER_BIT/2 the line is rechecked; if it is high, the start was false and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that. The stop bit is sampled last.
  - Stop bit = 1 → one-cycle internal byte_valid. Stop bit = 0 → framing error; no byte_valid.
- States: IDLE, COUNT, LOAD, CHECK, RUN, ERROR.
  - IDLE: non-HEADER bytes and framing errors are ignored. HEADER → COUNT; clears words_loaded and the checksum.
  - COUNT: the next byte sets the word total → LOAD.
  - LOAD: bytes shift into a 32-bit assembler. On each 4th byte the word is written (see Timing), words_loaded increments, and the checksum accumulates every byte. After the last word → CHECK.
  - CHECK: byte equal to the checksum → RUN; otherwise → ERROR.
  - RUN: HEADER → COUNT (reload); other bytes are ignored.
  - ERROR: HEADER → COUNT; other bytes are ignored.
  - Any framing error in COUNT, LOAD or CHECK → ERROR.
- Outputs by state:
  - IDLE, COUNT, LOAD, CHECK, ERROR: comp_rst = 0, comp_en = 1.
  - RUN: comp_rst = 1, comp_en = 0.
  - busy = 1 in COUNT, LOAD and CHECK; done = 1 in RUN; error = 1 in ERROR.
- Entering COUNT from RUN re-asserts computer reset the cycle after HEADER's byte_valid.
- Memory is written before the checksum is verified. On ERROR the computer stays in reset, so partial contents are harmless.
- Reset values: comp_rst 0, comp_en 1, wr_instr_en 0, wr_instr_addr 0, wr_instr 0, busy 0, done 0, error 0, words_loaded 0. State = IDLE; receiver idle.
- rst mid-frame aborts immediately. Partially received bytes are discarded; no write strobe is emitted.

## Timing
- byte_valid occurs CLKS_PER_BIT·9.5 + 2 (±1) cycles after the rx falling edge at the pin.
- Write strobe:
  - The cycle after the 4th byte's byte_valid: wr_instr_en = 1 for exactly one cycle.
  - wr_instr_addr = word index (0 .. N−1) and wr_instr = assembled word, both valid in that same cycle.
  - words_loaded updates in that same cycle.
- wr_instr_addr and wr_instr hold their last values after the strobe; there are never back-to-back strobes.
- RUN/ERROR transitions, and the corresponding comp_rst/comp_en changes, are registered the cycle after the checksum byte's byte_valid.
- The 128-word load wraps nothing: the final address is 127 and words_loaded = 128.

## Test plan
- CLKS_PER_BIT = 16 for all scenarios.
- Good load: send A5 02 20 08 00 07 AC 08 00 00 8B → two strobes (addr 0 = 32'h20080007, addr 1 = 32'hAC080000); then done = 1, comp_rst = 1, comp_en = 0, words_loaded = 2.
- Bad checksum: the same frame ending in 8A → error = 1, comp_rst = 0, comp_en = 1, done = 0. A following good frame → RUN.
- Count 0: A5 00, 512 bytes of 11, checksum 00 → 128 strobes; last addr 127, word 32'h11111111; words_loaded = 128; RUN.
- Framing error: stop bit forced 0 on the 3rd instruction byte → ERROR with no strobe for word 0. Then HEADER → busy = 1, words_loaded = 0.
- Noise and ignore:
  - rx low for 6 cycles → no byte.
  - Bytes 3C FF in IDLE → state stays IDLE.
  - 3C in RUN → done stays 1.
- Reset mid-frame: rst pulsed during the 2nd word → all outputs at reset values, state IDLE, no strobe. The next full frame loads correctly.
